ysyx_23060061_ifu: RTL and testbench

Instruction fetch unit that sits directly upstream of the core's decode/execute datapath. It owns the program counter, issues single-outstanding fetch requests to instruction memory over a valid/ready request/response pair, and presents each fetched instruction with its PC to the downstream stage over a valid/ready handshake. Control-flow redirects from downstream replace sequential PC+4 and squash any stale fetch.

---
 rtl/ysyx_23060061_ifu.sv | 139 +++++++++++++
 tb/tb_ysyx_23060061_ifu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and hands each instruction downstream.
// Optional misaligned-redirect trap is enabled by defining YSYX_23060061_IFU_ALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | just out of reset, request goes out next cycle
// REQ   | fetch request presented at pc, waiting for memory to accept
// WAIT  | request accepted, waiting for the response word
// OUT   | instruction held for downstream until consumed or redirected
// FAULT | misaligned redirect seen, everything parked until reset
module ysyx_23060061_ifu #(
    parameter logic [31:0] RESET_PC = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mem_resp_ready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] OUT   = 3'd3;
    localparam logic [2:0] FAULT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        stale_q, stale_d;
    logic [31:0] redirect_target;
    logic        redirect_bad;

    assign redirect_target = redirect_pc & ~32'h3;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign_err = (state_q == FAULT);
`else
    assign redirect_bad = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Moore outputs only: nothing downstream sees inst_ready or mem_resp_valid combinationally
    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = pc_q;
    assign mem_resp_ready = (state_q == WAIT);
    assign inst_valid     = (state_q == OUT);
    assign inst           = inst_q;
    assign inst_pc        = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        stale_d = stale_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (mem_req_ready) begin
                        stale_d = 1'b1;
                        state_d = WAIT;
                    end
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (mem_resp_valid) begin
                    // a response for a superseded PC is swallowed here
                    if (stale_q || redirect_valid) begin
                        stale_d = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d  = mem_resp_data;
                        state_d = OUT;
                    end
                end else if (redirect_valid) begin
                    stale_d = 1'b1;
                end
            end
            OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (redirect_bad) begin
            state_d = FAULT;
            pc_d    = pc_q;
            inst_d  = inst_q;
            stale_d = stale_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            stale_q <= stale_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Directed bench for ysyx_23060061_ifu; the bench drives memory and downstream handshakes by hand.
// Build with YSYX_23060061_IFU_ALIGN_CHECK_EN defined to exercise the fault path.
module tb_ysyx_23060061_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        mem_resp_ready;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    ysyx_23060061_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // starts in REQ at addr, ends in OUT holding data
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        check("req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("req_addr", mem_req_addr, addr);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("wait_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
        check("wait_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        tick();
        mem_resp_valid = 1'b0;
        check("out_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("out_inst", inst, data);
        check("out_inst_pc", inst_pc, addr);
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h80000000);
        check("rst_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h80000000);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);

        rst = 1'b0;
        check("idle_req_valid", {31'b0, mem_req_valid}, 32'd0);
        tick();

        // sequential stream, 3 cycles per instruction
        fetch(32'h80000000, 32'h00100093);
        consume();
        fetch(32'h80000004, 32'h00200113);
        consume();
        fetch(32'h80000008, 32'h00308193);
        consume();

        // downstream stall holds the instruction steady
        fetch(32'h8000000C, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'hCAFEF00D);
            check("stall_inst_pc", inst_pc, 32'h8000000C);
            check("stall_req_valid", {31'b0, mem_req_valid}, 32'd0);
        end
        consume();
        check("after_stall_addr", mem_req_addr, 32'h80000010);

        // redirect while waiting, response two cycles later is dropped
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000100;
        tick();
        redirect_valid = 1'b0;
        check("wait_redir_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
        tick();
        check("wait_redir_inst_valid", {31'b0, inst_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        check("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("drop_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("drop_req_addr", mem_req_addr, 32'h80000100);
        fetch(32'h80000100, 32'h12345678);
        consume();

        // redirect beats inst_ready in OUT
        fetch(32'h80000104, 32'h87654321);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000200;
        tick();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        check("out_redir_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("out_redir_addr", mem_req_addr, 32'h80000200);

        // redirect in REQ without handshake, then PC wrap
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFFFFFC;
        tick();
        redirect_valid = 1'b0;
        fetch(32'hFFFFFFFC, 32'h0000006F);
        consume();
        check("wrap_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("wrap_addr", mem_req_addr, 32'h00000000);

        // redirect on the accepting cycle makes the response stale
        mem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000300;
        tick();
        mem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        check("hs_redir_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
        check("hs_redir_addr", mem_req_addr, 32'h80000300);
        mem_resp_valid = 1'b1;
        mem_resp_data = 32'hBADBAD00;
        tick();
        mem_resp_valid = 1'b0;
        check("hs_drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("hs_drop_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("hs_drop_addr", mem_req_addr, 32'h80000300);

        // misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h80000002;
        tick();
        redirect_valid = 1'b0;
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check("fault_misalign", {31'b0, misalign_err}, 32'd1);
            check("fault_req_valid", {31'b0, mem_req_valid}, 32'd0);
            check("fault_inst_valid", {31'b0, inst_valid}, 32'd0);
            check("fault_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        check("fault_rst_misalign", {31'b0, misalign_err}, 32'd0);
        rst = 1'b0;
        tick();
        check("fault_rst_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("fault_rst_addr", mem_req_addr, 32'h80000000);
`else
        check("noalign_misalign", {31'b0, misalign_err}, 32'd0);
        check("noalign_req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("noalign_addr", mem_req_addr, 32'h80000000);
        fetch(32'h80000000, 32'h00000013);
        consume();
        check("noalign_next_addr", mem_req_addr, 32'h80000004);
`endif

        // asynchronous reset from WAIT, sampled mid-cycle
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("pre_arst_resp_ready", {31'b0, mem_resp_ready}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_resp_ready", {31'b0, mem_resp_ready}, 32'd0);
        check("arst_addr", mem_req_addr, 32'h80000000);
        check("arst_inst", inst, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_restart_req_valid", {31'b0, mem_req_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
